counter_mod_updown: RTL and testbench

Parametrised successor to the fixed-modulus free-running counter used in the FND driver.
- Adds runtime-programmable modulus, enable, up/down direction, parallel load, one-shot mode and a registered terminal-count tick.
- Used for digit-scan dividers, dice-roll timers and countdown displays in the game-logic path.
- Single clock domain, asynchronous active-low reset.

---
 rtl/counter_mod_updown.sv | 109 ++++++++++
 tb/tb_counter_mod_updown.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/counter_mod_updown.sv
// Up/down modulo-M counter with runtime modulus, parallel load, one-shot mode and terminal tick.
// Optional enable prescaler is built when CNT_PRESCALE_EN is defined.
module counter_mod_updown #(
    parameter int MAX_N    = 10000,
    parameter int W        = $clog2(MAX_N),
    parameter int PRESCALE = 100000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         up,
    input  logic         oneshot,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] mod_n,
    output logic [W-1:0] count,
    output logic         tick,
    output logic         done
);

    localparam logic [W:0]   MAX_X  = (W+1)'(MAX_N);
    localparam logic [W-1:0] MAX_M1 = W'(MAX_N - 1);

    // Largest legal count (Me-1); mod_n of 0 or above MAX_N selects MAX_N.
    function automatic logic [W-1:0] eff_top(input logic [W-1:0] m);
        if (m == '0 || {1'b0, m} > MAX_X)
            return MAX_M1;
        else
            return m - 1'b1;
    endfunction

    function automatic logic [W-1:0] sat_top(input logic [W-1:0] v, input logic [W-1:0] top);
        return (v > top) ? top : v;
    endfunction

    logic [W-1:0] top;
    logic [W-1:0] term;
    logic [W-1:0] start;
    logic [W-1:0] nxt;
    logic         at_term;
    logic         out_rng;
    logic         step;

    assign top     = eff_top(mod_n);
    assign term    = up ? top : '0;
    assign start   = up ? '0 : top;
    assign nxt     = up ? count + 1'b1 : count - 1'b1;
    assign at_term = (count == term);
    assign out_rng = (count > top);

`ifdef CNT_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PW-1:0] pcnt;
    logic          hit;

    assign hit  = (pcnt == PW'(PRESCALE - 1));
    assign step = en & hit;

    // Prescaler freezes while en is low and restarts on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pcnt <= '0;
        else if (load)
            pcnt <= '0;
        else if (en)
            pcnt <= hit ? '0 : pcnt + 1'b1;
    end
`else
    logic unused_prescale;
    assign unused_prescale = (PRESCALE != 0);
    assign step = en;
`endif

    // Wrap compare happens before the increment so count never leaves 0..Me-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tick  <= 1'b0;
            done  <= 1'b0;
        end else if (load) begin
            count <= sat_top(load_val, top);
            tick  <= 1'b0;
            done  <= 1'b0;
        end else if (step) begin
            if (oneshot) begin
                if (done) begin
                    tick <= 1'b0;
                end else if (at_term || out_rng) begin
                    count <= term;
                    done  <= 1'b1;
                    tick  <= 1'b1;
                end else begin
                    count <= nxt;
                    tick  <= 1'b0;
                end
            end else if (at_term || out_rng) begin
                count <= start;
                tick  <= 1'b1;
            end else begin
                count <= nxt;
                tick  <= 1'b0;
            end
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter_mod_updown.sv
// Directed-vector bench for counter_mod_updown (default MAX_N=10000, W=14).
module tb_counter_mod_updown;

    localparam int MAX_N = 10000;
    localparam int W     = 14;
`ifdef CNT_PRESCALE_EN
    localparam int PS = 3;
`else
    localparam int PS = 100000;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en, up, oneshot, load;
    logic [W-1:0] load_val, mod_n;
    logic [W-1:0] count;
    logic         tick, done;

    int errs   = 0;
    int checks = 0;

    counter_mod_updown #(.MAX_N(MAX_N), .W(W), .PRESCALE(PS)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .oneshot(oneshot),
        .load(load), .load_val(load_val), .mod_n(mod_n),
        .count(count), .tick(tick), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int v);
        load = 1'b1; load_val = W'(v);
        cyc();
        load = 1'b0;
    endtask

    int ticks;
    int exp3_c[4] = '{1, 0, 5, 4};
    int exp3_t[4] = '{0, 0, 1, 0};
    int exp4_c[6] = '{1, 2, 3, 3, 3, 3};
    int exp4_t[6] = '{0, 0, 0, 1, 0, 0};
    int exp4_d[6] = '{0, 0, 0, 1, 1, 1};
    int exp6_c[11] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3};
    int exp6_e[11] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 1};

    initial begin
        rst_n = 1'b0; en = 1'b0; up = 1'b1; oneshot = 1'b0; load = 1'b0;
        load_val = '0; mod_n = W'(10);
        #12;
        chk("reset_count", count, 0);
        chk("reset_tick", tick, 0);
        chk("reset_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

`ifdef CNT_PRESCALE_EN
        mod_n = W'(4);
        do_load(0);
        for (int i = 0; i < 11; i++) begin
            en = exp6_e[i][0];
            cyc();
            chk($sformatf("pre_count[%0d]", i), count, exp6_c[i]);
        end
        en = 1'b0;
`else
        // Up-count mod 10 for 25 cycles.
        ticks = 0;
        en = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            cyc();
            chk($sformatf("up10_count[%0d]", i), count, i % 10);
            chk($sformatf("up10_tick[%0d]", i), tick, (i % 10 == 0) ? 1 : 0);
            ticks += tick;
        end
        chk("up10_ticks", ticks, 2);
        en = 1'b0;

        // Down-count mod 6 from loaded 2.
        mod_n = W'(6); up = 1'b0;
        do_load(2);
        chk("dn6_load", count, 2);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("dn6_count[%0d]", i), count, exp3_c[i]);
            chk($sformatf("dn6_tick[%0d]", i), tick, exp3_t[i]);
        end
        en = 1'b0;

        // One-shot mod 4 up.
        mod_n = W'(4); up = 1'b1; oneshot = 1'b1;
        do_load(0);
        en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk($sformatf("os_count[%0d]", i), count, exp4_c[i]);
            chk($sformatf("os_tick[%0d]", i), tick, exp4_t[i]);
            chk($sformatf("os_done[%0d]", i), done, exp4_d[i]);
        end
        // Clearing oneshot while done: wrap behaviour, done stays set.
        oneshot = 1'b0;
        cyc();
        chk("os_clr_count", count, 0);
        chk("os_clr_tick", tick, 1);
        chk("os_clr_done", done, 1);
        en = 1'b0; oneshot = 1'b1;
        do_load(0);
        chk("os_reload_done", done, 0);
        chk("os_reload_count", count, 0);
        en = 1'b1;
        cyc();
        chk("os_resume", count, 1);
        en = 1'b0; oneshot = 1'b0;

        // Modulus shrinks below current count.
        mod_n = W'(10);
        do_load(8);
        chk("shrink_load", count, 8);
        mod_n = W'(5); en = 1'b1;
        cyc();
        chk("shrink_count", count, 0);
        chk("shrink_tick", tick, 1);
        en = 1'b0;

        // mod_n=0 and mod_n>MAX_N both mean MAX_N.
        mod_n = '0;
        do_load(16000);
        chk("m0_clamp", count, MAX_N - 1);
        en = 1'b1;
        cyc();
        chk("m0_wrap_count", count, 0);
        chk("m0_wrap_tick", tick, 1);
        up = 1'b0;
        cyc();
        chk("m0_down_count", count, MAX_N - 1);
        chk("m0_down_tick", tick, 1);
        en = 1'b0; up = 1'b1;
        mod_n = W'(12000);
        do_load(11000);
        chk("mbig_clamp", count, MAX_N - 1);

        // Load beats step in the same cycle.
        mod_n = W'(10);
        do_load(9);
        en = 1'b1; load = 1'b1; load_val = W'(7);
        cyc();
        load = 1'b0; en = 1'b0;
        chk("ld_win_count", count, 7);
        chk("ld_win_tick", tick, 0);
        cyc();
        chk("hold_count", count, 7);

        // Asynchronous reset right after done/tick rise.
        mod_n = W'(4); oneshot = 1'b1;
        do_load(3);
        en = 1'b1;
        cyc();
        chk("pre_rst_tick", tick, 1);
        chk("pre_rst_done", done, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_tick", tick, 0);
        chk("arst_done", done, 0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
`endif
        cyc();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
